div_seq32: RTL
==============

# div_seq32

Sequential radix-2 restoring integer divider for the CPU32 datapath. It is the inverse counterpart to the combinational multiplier. It produces a quotient and a remainder one bit per cycle under a start/done handshake. It supports signed and unsigned operands, and its divide-by-zero and overflow results follow RISC-V DIV/DIVU/REM/REMU semantics.

## Interface
- W, default 32, operand width in bits. The same width applies to dividend, divisor, quotient and remainder.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a division. Sampled only in IDLE.
- signed_op  input  1  1 selects two's-complement operands; 0 selects unsigned. Captured with start.
- dividend  input  W  numerator. Captured with start.
- divisor  input  W  denominator. Captured with start.
- busy  output  1  high while a division is in progress (CALC or FIX).
- done  output  1  one-cycle pulse indicating that the results are valid.
- quotient  output  W  registered result. Held until the next done.
- remainder  output  W  registered result. Held until the next done.
- div_by_zero  output  1  set with done when the captured divisor was 0. Held with the results.

## Operation
- The state machine has three states: IDLE, CALC and FIX.
- IDLE:
  - On start=1, capture signed_op, the operand signs, and the magnitudes |dividend| and |divisor|. Magnitudes are computed only when signed_op=1; otherwise the raw values are used.
  - Clear the partial remainder (W+1 bits), load the iteration counter with W, and go to CALC.
  - Otherwise remain in IDLE.
- CALC, one iteration per cycle:
  - Shift {rem, quo} left by 1, bringing in the dividend MSB first.
  - Compute trial = rem - divisor_mag at W+1 bits.
  - If trial is non-negative, rem = trial and the quotient LSB is 1. Otherwise rem is unchanged and the quotient LSB is 0.
  - Decrement the counter. After the W-th iteration, go to FIX.
- FIX, one cycle:
  - Apply sign correction when signed_op=1. The quotient is negated if the dividend and divisor signs differ. The remainder is negated if the dividend was negative, so the remainder always takes the dividend's sign.
  - Apply the overrides below, then register quotient, remainder and div_by_zero.
  - Pulse done and return to IDLE.
- Divide-by-zero override, for both signed and unsigned operation:
  - quotient = all ones.
  - remainder = the original dividend, not its magnitude.
  - div_by_zero = 1.
- Signed overflow (dividend = 2^(W-1) with bit W-1 set, divisor = all ones, signed_op=1): quotient = 2^(W-1) and remainder = 0. The algorithm produces this result naturally; no override is needed. div_by_zero = 0.
- The magnitude of 2^(W-1) is 2^(W-1) as an unsigned value. The magnitude path is W bits unsigned and has no overflow.
- Input changes while busy are ignored. The operands are used only from the captured registers.

## Timing
- Reset values: busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, state IDLE.
- The edge that samples start=1 in IDLE is edge 0.
  - busy goes high after edge 0.
  - CALC occupies edges 1..W.
  - FIX is evaluated at edge W+1.
  - done=1 and the new results are visible in the cycle after edge W+1. This is a fixed latency of W+1 edges, with no early-out.
- Latency is independent of the operand values, including divide-by-zero.
- busy falls in the same cycle that done rises.
- done stays high for exactly one cycle.
- start asserted in the done cycle is accepted, because the state is IDLE. Back-to-back throughput is one division per W+2 cycles.
- start asserted while busy is ignored. No queuing is performed.
- Asserting rst_n low at any time, including mid-CALC, immediately forces the reset values. The aborted division produces no done pulse.
- Results persist until overwritten by the next FIX.

## Test plan
- Unsigned 100 / 7, with start at edge 0:
  - done is seen after edge 33 (W=32), never earlier.
  - quotient=14, remainder=2, div_by_zero=0.
  - busy is high for exactly 33 cycles.
- Signed -7 / 2 (0xFFFFFFF9, 0x00000002): quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1).
- Signed 7 / -2: quotient=0xFFFFFFFD, remainder=0x00000001.
- Divide by zero:
  - Unsigned 0x00001234 / 0: quotient=0xFFFFFFFF, remainder=0x00001234, div_by_zero=1.
  - Signed 0xFFFFFF00 / 0: quotient=0xFFFFFFFF, remainder=0xFFFFFF00, div_by_zero=1.
- Signed overflow 0x80000000 / 0xFFFFFFFF: quotient=0x80000000, remainder=0, div_by_zero=0.
- Unsigned 0xFFFFFFFF / 1: quotient=0xFFFFFFFF, remainder=0.
- Handshake and reset:
  - Start 50/5. Pulse start again with 9/3 at edge 10. The second start is ignored, and the results are quotient=10, remainder=0.
  - Start again in the done cycle. The next done arrives 33 edges later.
  - Drop rst_n at edge 15 of another division. All outputs read 0 immediately, and no done pulse follows.

Source files
------------

// File: rtl/div_seq32.sv
// Sequential radix-2 restoring divider: one quotient bit per cycle, signed/unsigned,
// RISC-V style divide-by-zero and overflow results, start/done handshake.
module div_seq32 #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         signed_op,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         div_by_zero
);

    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    state_t         state;
    logic [CW-1:0]  count;
    logic [W-1:0]   rem;
    logic [W-1:0]   quo;
    logic [W-1:0]   dvs_mag;
    logic [W-1:0]   dvd_orig;
    logic           dvd_neg;
    logic           dvs_neg;

    logic [W-1:0]   dvd_mag_in;
    logic [W-1:0]   dvs_mag_in;
    logic [W:0]     shifted;
    logic [W:0]     trial;
    logic [W-1:0]   rem_next;
    logic [W-1:0]   quo_fix;
    logic [W-1:0]   rem_fix;
    logic           zero_div;

    // Operand magnitudes; -(2^(W-1)) maps to 2^(W-1) as an unsigned W-bit value.
    always_comb begin
        dvd_mag_in = dividend;
        dvs_mag_in = divisor;
        if (signed_op && dividend[W-1]) dvd_mag_in = -dividend;
        if (signed_op && divisor[W-1])  dvs_mag_in = -divisor;
    end

    // The shifted partial remainder needs W+1 bits; the stored remainder is always
    // below the divisor magnitude, so it fits in W bits between iterations.
    always_comb begin
        shifted  = {rem, quo[W-1]};
        trial    = shifted - {1'b0, dvs_mag};
        rem_next = trial[W] ? shifted[W-1:0] : trial[W-1:0];
    end

    always_comb begin
        zero_div = (dvs_mag == '0);
        quo_fix  = (dvd_neg ^ dvs_neg) ? -quo : quo;
        rem_fix  = dvd_neg ? -rem : rem;
        if (zero_div) begin
            quo_fix = '1;
            rem_fix = dvd_orig;
        end
    end

    // NOTE: every register here is updated with <= so all reads in this block see
    // the pre-edge values; blocking assignments would chain iterations within a cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            count       <= '0;
            rem         <= '0;
            quo         <= '0;
            dvs_mag     <= '0;
            dvd_orig    <= '0;
            dvd_neg     <= 1'b0;
            dvs_neg     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        dvd_neg  <= signed_op & dividend[W-1];
                        dvs_neg  <= signed_op & divisor[W-1];
                        quo      <= dvd_mag_in;
                        dvs_mag  <= dvs_mag_in;
                        dvd_orig <= dividend;
                        rem      <= '0;
                        count    <= CW'(W);
                        busy     <= 1'b1;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    rem   <= rem_next;
                    quo   <= {quo[W-2:0], ~trial[W]};
                    count <= count - CW'(1);
                    if (count == CW'(1)) state <= FIX;
                end
                FIX: begin
                    quotient    <= quo_fix;
                    remainder   <= rem_fix;
                    div_by_zero <= zero_div;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
